jacobi_2d_kernel: RTL and testbench

- Fixed-size 2-D Jacobi stencil accelerator with a Vivado-HLS-style block-level handshake (ap_ctrl_hs).
- Operates in place on one external 32-bit word memory, reached through two RAM-style ports.
- Sits under the memory-bridge wrapper, which turns every port access into a host read or write.
- Array A occupies words 0..N*N-1 (row-major); scratch array B occupies words N*N..2*N*N-1.

---
 rtl/jacobi_2d_kernel.sv | 255 +++++++++++++++++++++++++
 tb/tb_jacobi_2d_kernel.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_2d_kernel.sv
// jacobi_2d_kernel: in-place 2-D Jacobi stencil over one external word memory.
// Array A lives at words 0..N*N-1 and scratch B at N*N..2*N*N-1 (row-major).
// Each time step runs one A->B sweep and then one B->A sweep over the interior points.
// Every interior point gets (C + L + R + U + D) / 5, using signed 32-bit wrap-around
// arithmetic and division that truncates toward zero.
//
// Build option JACOBI_DUAL_PORT_EN:
//   defined   - the five reads use both ports, 4 cycles per point.
//   undefined - all five reads go through port0, 6 cycles per point.
//               Port1 outputs are tied low.
//
// Ports:
//   ap_clk, ap_rst_n              clock; asynchronous active-low reset
//   ap_start                      level start request, sampled only in IDLE
//   ap_done, ap_ready             one-cycle completion pulse
//   ap_idle                       high while in IDLE
//   A_address*/A_ce*/A_we*/A_d*   RAM-style request ports (registered)
//   A_q0, A_q1                    read data, valid one cycle after the read request
//   A_d0                          the only combinational output: the result written in WR
//
// Sizing: 2*N*N must fit in the 14-bit word address space (at most 16384 words).
module jacobi_2d_kernel #(
  parameter int unsigned N      = 64,
  parameter int unsigned TSTEPS = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [13:0] A_address0,
  output logic        A_ce0,
  output logic        A_we0,
  output logic [31:0] A_d0,
  input  logic [31:0] A_q0,
  output logic [13:0] A_address1,
  output logic        A_ce1,
  output logic        A_we1,
  output logic [31:0] A_d1,
  input  logic [31:0] A_q1
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TSTEPS + 1);

  localparam logic [AW-1:0] NN    = AW'(N * N);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(N - 2);
  localparam logic [TW-1:0] TONE  = TW'(1);
  localparam logic [TW-1:0] TLAST = TW'(TSTEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_WR, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_t, w_t_nxt;
  logic [CW-1:0] r_i, w_i_nxt, r_j, w_j_nxt;
  logic          r_sweep, w_sweep_nxt;   // 0: A->B, 1: B->A
  logic          w_last;

  logic          r_done, r_idle, r_ce0, r_ce1, r_we0;
  logic [AW-1:0] r_addr0, r_addr1;
  logic          w_done_nxt, w_idle_nxt, w_ce0_nxt, w_ce1_nxt, w_we0_nxt;
  logic [AW-1:0] w_addr0_nxt, w_addr1_nxt;
  logic [AW-1:0] w_src, w_dst;
  logic [AW-1:0] w_a_c, w_a_l, w_a_r, w_a_u, w_a_d, w_a_w;

  logic [DW-1:0]        r_c, r_l, r_r, r_u;
  logic [DW-1:0]        w_sum;
  logic signed [DW-1:0] w_quot;

  // Word address of element (i, j) in the array at base.
  function automatic logic [AW-1:0] f_addr(input logic [AW-1:0] base,
                                           input logic [CW-1:0] i,
                                           input logic [CW-1:0] j);
    return base + AW'(i) * AW'(N) + AW'(j);
  endfunction

  // State, loop counters and registered outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_sweep <= 1'b0;
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
      r_ce0   <= 1'b0;
      r_ce1   <= 1'b0;
      r_we0   <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_sweep <= w_sweep_nxt;
      r_done  <= w_done_nxt;
      r_idle  <= w_idle_nxt;
      r_ce0   <= w_ce0_nxt;
      r_ce1   <= w_ce1_nxt;
      r_we0   <= w_we0_nxt;
      r_addr0 <= w_addr0_nxt;
      r_addr1 <= w_addr1_nxt;
    end
  end

  // Next state and counters. The outputs are decoded from the next state,
  // so each registered request lines up with the state that issues it.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_sweep_nxt = r_sweep;
    w_last      = 1'b0;
    w_done_nxt  = 1'b0;
    w_idle_nxt  = 1'b0;
    w_ce0_nxt   = 1'b0;
    w_ce1_nxt   = 1'b0;
    w_we0_nxt   = 1'b0;
    w_addr0_nxt = '0;
    w_addr1_nxt = '0;

    case (r_state)
      S_IDLE: if (ap_start) begin
        w_state_nxt = S_RD0;
        w_t_nxt     = '0;
        w_sweep_nxt = 1'b0;
        w_i_nxt     = ONE;
        w_j_nxt     = ONE;
      end
      S_RD0: w_state_nxt = S_RD1;
      S_RD1: w_state_nxt = S_RD2;
`ifdef JACOBI_DUAL_PORT_EN
      S_RD2: w_state_nxt = S_WR;
`else
      S_RD2: w_state_nxt = S_RD3;
      S_RD3: w_state_nxt = S_RD4;
      S_RD4: w_state_nxt = S_WR;
`endif
      S_WR: begin
        // Step order: j first, then i, then sweep, then t.
        if (r_j != LAST) begin
          w_j_nxt = r_j + ONE;
        end else begin
          w_j_nxt = ONE;
          if (r_i != LAST) begin
            w_i_nxt = r_i + ONE;
          end else begin
            w_i_nxt = ONE;
            if (!r_sweep) begin
              w_sweep_nxt = 1'b1;
            end else begin
              w_sweep_nxt = 1'b0;
              if (r_t == TLAST) w_last = 1'b1;
              else              w_t_nxt = r_t + TONE;
            end
          end
        end
        w_state_nxt = w_last ? S_DONE : S_RD0;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_src = w_sweep_nxt ? NN : '0;
    w_dst = w_sweep_nxt ? '0 : NN;
    w_a_c = f_addr(w_src, w_i_nxt, w_j_nxt);
    w_a_l = f_addr(w_src, w_i_nxt, w_j_nxt - ONE);
    w_a_r = f_addr(w_src, w_i_nxt, w_j_nxt + ONE);
    w_a_u = f_addr(w_src, w_i_nxt - ONE, w_j_nxt);
    w_a_d = f_addr(w_src, w_i_nxt + ONE, w_j_nxt);
    w_a_w = f_addr(w_dst, w_i_nxt, w_j_nxt);

    case (w_state_nxt)
      S_IDLE: w_idle_nxt = 1'b1;
      S_DONE: w_done_nxt = 1'b1;
`ifdef JACOBI_DUAL_PORT_EN
      S_RD0: begin
        w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_c;
        w_ce1_nxt = 1'b1; w_addr1_nxt = w_a_l;
      end
      S_RD1: begin
        w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_r;
        w_ce1_nxt = 1'b1; w_addr1_nxt = w_a_u;
      end
      S_RD2: begin w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_d; end
`else
      S_RD0: begin w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_c; end
      S_RD1: begin w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_l; end
      S_RD2: begin w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_r; end
      S_RD3: begin w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_u; end
      S_RD4: begin w_ce0_nxt = 1'b1; w_addr0_nxt = w_a_d; end
`endif
      S_WR: begin
        w_ce0_nxt   = 1'b1;
        w_we0_nxt   = 1'b1;
        w_addr0_nxt = w_a_w;
      end
      default: ;
    endcase
  end

  // Capture neighbour words as they come back; D is used directly from A_q0 in WR.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_c <= '0;
      r_l <= '0;
      r_r <= '0;
      r_u <= '0;
    end else begin
      case (r_state)
`ifdef JACOBI_DUAL_PORT_EN
        S_RD1: begin r_c <= A_q0; r_l <= A_q1; end
        S_RD2: begin r_r <= A_q0; r_u <= A_q1; end
`else
        S_RD1: r_c <= A_q0;
        S_RD2: r_l <= A_q0;
        S_RD3: r_r <= A_q0;
        S_RD4: r_u <= A_q0;
`endif
        default: ;
      endcase
    end
  end

`ifndef JACOBI_DUAL_PORT_EN
  logic w_unused_q1;
  assign w_unused_q1 = ^A_q1;
`endif

  // The sum wraps modulo 2^32. Signed division truncates toward zero.
  assign w_sum  = r_c + r_l + r_r + r_u + A_q0;
  assign w_quot = $signed(w_sum) / 32'sd5;

  assign ap_done    = r_done;
  assign ap_ready   = r_done;
  assign ap_idle    = r_idle;
  assign A_address0 = r_addr0;
  assign A_ce0      = r_ce0;
  assign A_we0      = r_we0;
  assign A_d0       = (r_state == S_WR) ? $unsigned(w_quot) : '0;
  assign A_address1 = r_addr1;
  assign A_ce1      = r_ce1;
  assign A_we1      = 1'b0;
  assign A_d1       = '0;

endmodule

// File: tb/tb_jacobi_2d_kernel.sv
// Testbench for jacobi_2d_kernel with N=4 and TSTEPS=1, backed by a 32-word RAM model.
// A reference Jacobi model computes the expected memory image.
// Stimulus comes from a directed vector table and randomized fields.
// Handshake timing, reset and abort behaviour are checked by hand-written sequences.
module tb_jacobi_2d_kernel;

  localparam int N    = 4;
  localparam int TS   = 1;
  localparam int MW   = 2 * N * N;
  localparam int NPTS = 2 * TS * (N - 2) * (N - 2);
`ifdef JACOBI_DUAL_PORT_EN
  localparam int CPP = 4;
`else
  localparam int CPP = 6;
`endif
  localparam int EXP_DONE = NPTS * CPP + 1;
  localparam int NV       = 22;

  typedef struct packed {
    int kind;
    int addr;
    int expv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done, idle, ready;
  logic [13:0] addr0, addr1;
  logic        ce0, ce1, we0, we1;
  logic [31:0] d0, d1;
  logic [31:0] q0 = '0;
  logic [31:0] q1 = '0;

  int   init_mem[MW];
  int   mem[MW];
  int   exp_mem[MW];
  logic load_req = 1'b0;
  int   acc_cnt  = 0;
  int   wr_cnt   = 0;
  int   viol_cnt = 0;
  int   n_chk    = 0;
  int   n_err    = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  jacobi_2d_kernel #(.N(N), .TSTEPS(TS)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start),
    .ap_done(done), .ap_idle(idle), .ap_ready(ready),
    .A_address0(addr0), .A_ce0(ce0), .A_we0(we0), .A_d0(d0), .A_q0(q0),
    .A_address1(addr1), .A_ce1(ce1), .A_we1(we1), .A_d1(d1), .A_q1(q1)
  );

  function automatic bit is_edge(input int a);
    int k, r, c;
    k = a % (N * N);
    r = k / N;
    c = k % N;
    return (r == 0) || (r == N - 1) || (c == 0) || (c == N - 1);
  endfunction

  // Illegal access patterns seen in one cycle.
  function automatic int viol_now(input logic c0, input logic w0, input logic [13:0] a0,
                                  input logic c1, input logic w1, input logic [13:0] a1);
    int v;
    v = 0;
    if (c0 && int'(a0) >= MW) v++;
    if (c0 && w0 && is_edge(int'(a0))) v++;
    if (c0 && c1 && a0 == a1) v++;
`ifdef JACOBI_DUAL_PORT_EN
    if (c1 && (w1 || int'(a1) >= MW)) v++;
`else
    if (c1 || w1) v++;
`endif
    return v;
  endfunction

  // RAM model: one-cycle read latency, write on ce&&we.
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < MW; k++) mem[k] <= init_mem[k];
    end else begin
      acc_cnt  <= acc_cnt + ((ce0 || ce1) ? 1 : 0);
      wr_cnt   <= wr_cnt + ((ce0 && we0) ? 1 : 0);
      viol_cnt <= viol_cnt + viol_now(ce0, we0, addr0, ce1, we1, addr1);
      if (ce0 && int'(addr0) < MW) begin
        if (we0) mem[int'(addr0)] <= d0;
        else     q0 <= mem[int'(addr0)];
      end
      if (ce1 && !we1 && int'(addr1) < MW) q1 <= mem[int'(addr1)];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(expv));
    end
  endtask

  task automatic load();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  // Jacobi reference: whole-array sweeps with plain integer arithmetic.
  task automatic model_run();
    int s, d, sum;
    for (int k = 0; k < MW; k++) exp_mem[k] = init_mem[k];
    for (int t = 0; t < TS; t++) begin
      for (int sw = 0; sw < 2; sw++) begin
        s = (sw == 0) ? 0 : N * N;
        d = (sw == 0) ? N * N : 0;
        for (int i = 1; i <= N - 2; i++) begin
          for (int j = 1; j <= N - 2; j++) begin
            sum = exp_mem[s + i*N + j] + exp_mem[s + i*N + j - 1] + exp_mem[s + i*N + j + 1]
                + exp_mem[s + (i+1)*N + j] + exp_mem[s + (i-1)*N + j];
            exp_mem[d + i*N + j] = sum / 5;
          end
        end
      end
    end
  endtask

  function automatic int mem_diff();
    int n;
    n = 0;
    for (int k = 0; k < MW; k++) if (mem[k] != exp_mem[k]) n++;
    return n;
  endfunction

  task automatic set_init(input int kind);
    for (int k = 0; k < MW; k++) init_mem[k] = 0;
    case (kind)
      0: for (int k = 0; k < N*N; k++) init_mem[k] = 5;
      1: for (int k = 0; k < MW; k++) init_mem[k] = 5;
      2: init_mem[N + 1] = 25;
      3: init_mem[N + 1] = -7;
      default: ;
    endcase
  endtask

  // Start at edge 0 and return the cycle in which ap_done is first seen (-1 if it never is).
  task automatic run_dut(input bit hold, output int dcyc, output int rdy_bad, output int idle_bad);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    dcyc = -1; rdy_bad = 0; idle_bad = 0;
    for (int c = 1; c <= EXP_DONE + 100; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (ready !== done) rdy_bad++;
      if (done === 1'b1) begin dcyc = c; break; end
      if (idle !== 1'b0) idle_bad++;
    end
  endtask

  task automatic run_and_check(input string tag);
    int dcyc, rb, ib, w0, v0;
    w0 = wr_cnt; v0 = viol_cnt;
    run_dut(1'b0, dcyc, rb, ib);
    chk({tag, "_latency"}, dcyc, EXP_DONE);
    chk({tag, "_ready_eq_done"}, rb, 0);
    chk({tag, "_idle_while_busy"}, ib, 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 0);
    chk({tag, "_idle_after"}, {31'd0, idle}, 1);
    chk({tag, "_write_count"}, wr_cnt - w0, NPTS);
    chk({tag, "_access_violations"}, viol_cnt - v0, 0);
    chk({tag, "_words_off_model"}, mem_diff(), 0);
  endtask

  initial begin
    int dcyc, rb, ib, a0;

    // Directed expectations: {kind, word address, expected value}.
    vecs[0]  = '{0, 0, 5};   vecs[1]  = '{0, 5, 3};   vecs[2]  = '{0, 10, 3};
    vecs[3]  = '{0, 21, 5};  vecs[4]  = '{0, 26, 5};  vecs[5]  = '{0, 16, 0};
    vecs[6]  = '{0, 31, 0};
    vecs[7]  = '{1, 5, 5};   vecs[8]  = '{1, 22, 5};  vecs[9]  = '{1, 16, 5};
    vecs[10] = '{2, 21, 5};  vecs[11] = '{2, 22, 5};  vecs[12] = '{2, 25, 5};
    vecs[13] = '{2, 26, 0};  vecs[14] = '{2, 5, 3};   vecs[15] = '{2, 6, 2};
    vecs[16] = '{2, 9, 2};   vecs[17] = '{2, 10, 2};
    vecs[18] = '{3, 21, -1}; vecs[19] = '{3, 22, -1}; vecs[20] = '{3, 26, 0};
    vecs[21] = '{3, 5, 0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", {31'd0, idle}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ce", {30'd0, ce0, ce1}, 0);
    chk("rst_addr", {4'd0, addr0, addr1}, 0);
    chk("rst_d0", d0, 0);
    rst_n = 1'b1;
    a0 = acc_cnt;
    repeat (20) @(negedge clk);
    chk("quiet_after_reset", acc_cnt - a0, 0);
    chk("idle_after_reset", {31'd0, idle}, 1);

    for (int kind = 0; kind < 4; kind++) begin
      set_init(kind);
      load();
      model_run();
      run_and_check($sformatf("dir%0d", kind));
      for (int v = 0; v < NV; v++) begin
        if (vecs[v].kind == kind)
          chk($sformatf("vec%0d_addr%0d", v, vecs[v].addr), mem[vecs[v].addr], vecs[v].expv);
      end
    end

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < MW; k++)
        init_mem[k] = (r % 2 == 1) ? int'($urandom()) : int'($urandom_range(0, 2000)) - 1000;
      load();
      model_run();
      run_and_check($sformatf("rand%0d", r));
    end

    // Back-to-back run with ap_start held high, then an asynchronous abort mid-sweep.
    set_init(2);
    load();
    run_dut(1'b1, dcyc, rb, ib);
    chk("b2b_first_latency", dcyc, EXP_DONE);
    @(negedge clk);
    chk("b2b_idle_gap", {30'd0, idle, done}, 32'd2);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart_idle", {31'd0, idle}, 0);
    chk("b2b_restart_read", {17'd0, ce0, addr0}, {17'd0, 1'b1, 14'd5});
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    chk("busy_before_abort", {31'd0, ce0}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {28'd0, idle, done, ready, we0}, 32'd8);
    chk("abort_ce", {30'd0, ce0, ce1}, 0);
    chk("abort_addr", {4'd0, addr0, addr1}, 0);
    chk("abort_d0", d0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a0 = acc_cnt;
    repeat (5) @(negedge clk);
    chk("quiet_after_abort", acc_cnt - a0, 0);

    set_init(3);
    load();
    model_run();
    run_and_check("recover");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
